// File: rtl/accel_ctrl.sv
// accel_ctrl: job control and result writeback shell for the convolution
// accelerator. Latches a job configuration on start, pulses a datapath clear,
// translates virtual read addresses, arbitrates allocator results round-robin
// and writes them sequentially to the output region.
module accel_ctrl #(
  parameter int NUM_ALLOC = 4,
  parameter int DATA_W    = 18,
  parameter int ADDR_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             cfg_image_offset,
  input  logic [ADDR_W-1:0]             cfg_filter_offset,
  input  logic [ADDR_W-1:0]             cfg_output_offset,
  input  logic [15:0]                   cfg_result_count,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic                          sub_rst,
  input  logic                          issue_done,
  input  logic                          filter_done,
  input  logic [ADDR_W-1:0]             imem_addr_virt,
  output logic [ADDR_W-1:0]             imem_addr_phys,
  input  logic [ADDR_W-1:0]             fmem_addr_virt,
  output logic [ADDR_W-1:0]             fmem_addr_phys,
  input  logic [NUM_ALLOC-1:0]          result_ready,
  input  logic [NUM_ALLOC*DATA_W-1:0]   result_data,
  output logic [NUM_ALLOC-1:0]          result_ack,
  output logic [ADDR_W-1:0]             write_addr,
  output logic [DATA_W-1:0]             write_data,
  output logic                          write_en,
  output logic [15:0]                   results_written
);

  localparam int          PTR_W = (NUM_ALLOC > 1) ? $clog2(NUM_ALLOC) : 1;
  localparam int unsigned N_CH  = NUM_ALLOC;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state;
  logic              first_run;
  logic [ADDR_W-1:0] img_off;
  logic [ADDR_W-1:0] flt_off;
  logic [ADDR_W-1:0] out_off;
  logic [15:0]       res_cnt;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  gnt_idx;
  logic [PTR_W-1:0]  ptr_next;
  logic              gnt_vld;
  logic              arb_state;
  logic              arb_on;
  logic              overflow;
  int unsigned       cand;

  // Status decode and address translation
  always_comb begin
    busy           = (state == S_CLEAR) || (state == S_RUN) || (state == S_DRAIN);
    done           = (state == S_DONE);
    sub_rst        = (state == S_CLEAR);
    imem_addr_phys = imem_addr_virt + img_off;
    fmem_addr_phys = fmem_addr_virt + flt_off;
  end

  // Round-robin grant: first ready channel at or after ptr, cyclically.
  // Writes are counted on the edge that raises write_en, so the count alone
  // tells whether another result may still be accepted.
  always_comb begin
    arb_state  = (state == S_RUN) || (state == S_DRAIN);
    arb_on     = arb_state && (results_written != res_cnt);
    overflow   = arb_state && (results_written == res_cnt) && (|result_ready);
    gnt_vld    = 1'b0;
    gnt_idx    = '0;
    cand       = 0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= N_CH) cand = cand - N_CH;
      if (arb_on && !gnt_vld && result_ready[cand[PTR_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[PTR_W-1:0];
      end
    end
    result_ack = '0;
    if (gnt_vld) result_ack[gnt_idx] = 1'b1;
    ptr_next = (gnt_idx == PTR_W'(NUM_ALLOC - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Job FSM, configuration latch, pointer, error flag and writeback register
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      first_run       <= 1'b0;
      img_off         <= '0;
      flt_off         <= '0;
      out_off         <= '0;
      res_cnt         <= '0;
      ptr             <= '0;
      error           <= 1'b0;
      write_en        <= 1'b0;
      write_addr      <= '0;
      write_data      <= '0;
      results_written <= '0;
    end else begin
      write_en <= gnt_vld;
      if (gnt_vld) begin
        write_data      <= result_data[gnt_idx*DATA_W +: DATA_W];
        write_addr      <= out_off + ADDR_W'(results_written);
        results_written <= results_written + 16'd1;
        ptr             <= ptr_next;
      end
      if (overflow) error <= 1'b1;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            img_off         <= cfg_image_offset;
            flt_off         <= cfg_filter_offset;
            out_off         <= cfg_output_offset;
            res_cnt         <= cfg_result_count;
            results_written <= '0;
            ptr             <= '0;
            error           <= 1'b0;
            state           <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          first_run <= 1'b1;
          state     <= S_RUN;
        end
        S_RUN: begin
          first_run <= 1'b0;
          if (!first_run && issue_done && filter_done) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (results_written == res_cnt) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
